// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the SRAM front-end: controller state encoding,
//   default timing/geometry constants and the wait-counter width helper.
//   No ports; imported by sram_ctrl.
package sram_ctrl_pkg;

    localparam int STATE_WIDTH = 3;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_READ_WAIT  = 1;
    localparam int DEFAULT_WRITE_WAIT = 1;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    // Width needed to hold the longer of the two wait counts. Clamped to one
    // bit so an illegal zero wait still elaborates far enough to report it.
    function automatic int wait_cnt_width(input int read_wait, input int write_wait);
        int longest;
        longest = (read_wait > write_wait) ? read_wait : write_wait;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt
//   Loadable down-counter used to time the notOE and notWE pulses.
//   Ports:
//     clk        - system clock
//     notReset   - asynchronous active-low reset
//     load       - load load_value (takes priority over dec)
//     load_value - initial count, 1 or more
//     dec        - count down by one; stops at 1, never wraps
//     done       - high while the count is 1 (last cycle of the wait)
module sram_wait_cnt #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             notReset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Counting stops once done is reached; the zero guard keeps a stray
    // decrement after reset from wrapping to all ones.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !done && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Clocked valid/ready front-end for an asynchronous SRAM (active-low
//   notCS/notOE/notWE, write latched on the rising edge of notWE).
//   Ports:
//     clk, notReset          - clock, asynchronous active-low reset
//     req_valid/req_ready    - request handshake, accepted when both high
//     req_write              - 1 = write, 0 = read
//     req_addr, req_wdata    - request address and write data
//     rsp_valid, rsp_rdata   - one-cycle completion pulse, read data
//     mem_addr, mem_data     - SRAM address and bidirectional data bus
//     mem_notCS/OE/WE        - SRAM strobes, active low, glitch-free
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int READ_WAIT  = DEFAULT_READ_WAIT,
    parameter int WRITE_WAIT = DEFAULT_WRITE_WAIT
) (
    input  logic                  clk,
    input  logic                  notReset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_notCS,
    output logic                  mem_notOE,
    output logic                  mem_notWE
);

    if (READ_WAIT < 1) begin : g_bad_read_wait
        $error("sram_ctrl: READ_WAIT must be 1 or more");
    end
    if (WRITE_WAIT < 1) begin : g_bad_write_wait
        $error("sram_ctrl: WRITE_WAIT must be 1 or more");
    end

    localparam int CW = wait_cnt_width(READ_WAIT, WRITE_WAIT);
    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_WAIT);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_WAIT);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic                  cnt_done;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic cs_next;
    logic oe_next;
    logic we_next;
    logic drive_next;
    logic ready_next;
    logic rsp_next;
    logic capture_rdata;

    assign accept = req_valid && req_ready;

    // The same counter times both the read strobe and the write pulse. It is
    // loaded at accept, so it simply holds its value through WR_SETUP.
    sram_wait_cnt #(
        .WIDTH (CW)
    ) u_wait_cnt (
        .clk        (clk),
        .notReset   (notReset),
        .load       (accept),
        .load_value (req_write ? WRITE_LOAD : READ_LOAD),
        .dec        ((state == RD) || (state == WR_PULSE)),
        .done       (cnt_done)
    );

    // State register. Every mem_* output is registered here from a decode of
    // next_state, so the pins change only on a clock edge (or asynchronously
    // to their idle values on reset) and never glitch.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state     <= IDLE;
            mem_notCS <= 1'b1;
            mem_notOE <= 1'b1;
            mem_notWE <= 1'b1;
            drive_en  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
        end else begin
            state     <= next_state;
            mem_notCS <= !cs_next;
            mem_notOE <= !oe_next;
            mem_notWE <= !we_next;
            drive_en  <= drive_next;
            req_ready <= ready_next;
            rsp_valid <= rsp_next;
            if (accept) begin
                mem_addr <= req_addr;
            end
            if (capture_rdata) begin
                rsp_rdata <= mem_data;
            end
        end
    end

    // Write data is only ever seen on the bus behind drive_en, so it needs no
    // reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= req_wdata;
        end
    end

    // Next-state logic. Reads and writes both fall back to IDLE, which gives
    // the one-cycle bus turnaround between any two operations.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = req_write ? WR_SETUP : RD;
            RD:       if (cnt_done) next_state = IDLE;
            WR_SETUP: next_state = WR_PULSE;
            WR_PULSE: if (cnt_done) next_state = WR_HOLD;
            WR_HOLD:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode for the coming cycle. notOE is only asserted in RD and the
    // bus only driven in the write states, so they can never overlap.
    always_comb begin
        cs_next       = (next_state != IDLE);
        oe_next       = (next_state == RD);
        we_next       = (next_state == WR_PULSE);
        drive_next    = (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                        (next_state == WR_HOLD);
        ready_next    = (next_state == IDLE);
        capture_rdata = (state == RD) && cnt_done;
        rsp_next      = capture_rdata || (state == WR_HOLD);
    end

    assign mem_data = drive_en ? wdata_q : 'z;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous, parametrised front-end for the team's asynchronous SRAM (active-low notCS/notOE/notWE, write latched on the rising edge of notWE).
- Converts a clocked valid/ready request port into correctly sequenced SRAM strobes.
- Read and write wait states are configurable.
- Owns the bidirectional data bus.
- Sits between the CPU memory stage and the external SRAM.

Parameters:
- ADDR_WIDTH, 16, SRAM address width.
- DATA_WIDTH, 16, SRAM data width.
- READ_WAIT, 1, cycles notOE is held low before read data is sampled; legal range is 1 or more.
- WRITE_WAIT, 1, cycles notWE is held low; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- notReset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- req_ready  output  1  controller can accept a request this cycle.
- rsp_valid  output  1  one-cycle completion pulse (read and write).
- rsp_rdata  output  DATA_WIDTH  read data; valid when rsp_valid follows a read.
- mem_addr  output  ADDR_WIDTH  SRAM address.
- mem_data  inout  DATA_WIDTH  SRAM data bus.
- mem_notCS  output  1  SRAM chip select, active low.
- mem_notOE  output  1  SRAM output enable, active low.
- mem_notWE  output  1  SRAM write enable, active low.

Behaviour:
- Clocking and reset: one clock (clk); reset notReset is asynchronous, active-low.
- While notReset is low:
  - state = IDLE;
  - mem_notCS = mem_notOE = mem_notWE = 1; mem_data released (z);
  - mem_addr = 0, rsp_rdata = 0, rsp_valid = 0, req_ready = 0.
  - After release, req_ready = 1 from the first cycle.
- Handshake:
  - Request accepted on a rising edge where req_valid && req_ready.
  - req_ready is 1 only in IDLE.
  - Address, data and direction are captured into registers at accept; request inputs are ignored at all other times.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - All strobes high, bus released.
  - Accept read -> RD; accept write -> WR_SETUP. The wait counter is loaded at accept.
- RD:
  - notCS = 0, notOE = 0, notWE = 1; bus released.
  - Stays READ_WAIT cycles.
  - On the edge ending the last cycle: rsp_rdata <= mem_data, rsp_valid = 1 for the following cycle, go to IDLE (strobes high).
  - Read latency: rsp_valid asserts READ_WAIT+1 cycles after the accept edge.
- WR_SETUP (1 cycle):
  - notCS = 0, notOE = 1, notWE = 1; mem_data driven with the captured data.
- WR_PULSE (WRITE_WAIT cycles):
  - notWE = 0; notCS, bus and address unchanged.
- WR_HOLD (1 cycle):
  - notWE = 1, so the SRAM latches on the rising edge; notCS = 0; data still driven (hold).
  - Then -> IDLE with rsp_valid = 1 for one cycle; rsp_rdata unchanged.
  - Write occupancy: WRITE_WAIT+2 cycles.
- Bus rules:
  - mem_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD.
  - notOE is never low while the bus is driven.
  - notWE is never low outside WR_PULSE.
  - The mandatory IDLE cycle between operations is the bus turnaround cycle.
- Registering and glitches: strobes and address come from registers only; no combinational glitches on mem_* outputs.
- Back-to-back:
  - Next request is acceptable in the IDLE cycle where rsp_valid is high.
  - Minimum spacing between accepts: read READ_WAIT+1 cycles; write WRITE_WAIT+3 cycles.
- Wait counter: width $clog2(max(READ_WAIT, WRITE_WAIT)+1); counts down to 1, then the state exits; no wrap.
- Reset mid-operation:
  - Strobes go high and the bus releases immediately (asynchronously).
  - The in-flight operation is dropped; no rsp_valid is issued.
  - A write aborted in WR_PULSE may corrupt the target word; this is acceptable and not checked.
- Illegal parameters: READ_WAIT = 0 or WRITE_WAIT = 0 stops elaboration with $error/$finish in an initial block.

Decomposition:
- Shared header sram_defs.vh, include-guarded, holding:
  - state encoding localparams (IDLE = 0, RD = 1, WR_SETUP = 2, WR_PULSE = 3, WR_HOLD = 4), 3-bit state width;
  - default timing constants.
- One natural sub-module: sram_wait_cnt, a loadable down-counter with a done flag, parametrised width.
- FSM, capture registers and tristate driver live in sram_ctrl.

Test Plan:
- Reset, with READ_WAIT = 1, WRITE_WAIT = 1, backed by the team's async sram model: hold notReset low -> all strobes 1, mem_data z, req_ready 0; release -> req_ready 1 next cycle.
- Write then read: write 0x1234 to 0x00A5, then read 0x00A5 -> notWE low exactly 1 cycle; rsp_valid after the write at cycle 3; read rsp_rdata = 0x1234 with rsp_valid 2 cycles after accept.
- READ_WAIT = 3, WRITE_WAIT = 2: write 0xBEEF to 0xFFFF (top address), then read -> notWE low 2 cycles; notOE low 3 cycles; rsp_rdata = 0xBEEF 4 cycles after accept.
- Back-to-back: req_valid held high with writes to 0x0001..0x0004 (data 0x0011..0x0044), then 4 reads -> accepts spaced 4 and 2 cycles; reads return 0x0011..0x0044 in order; assertion that notOE is never low while mem_data is driven.
- Reset mid-write: notReset pulled low during WR_PULSE -> strobes high within the same time step, bus z, no rsp_valid; post-reset read of another address returns its prior value.
- Stalled input: req_valid high with changing req_addr while busy -> only the value present at the accept edge is used; req_ready 0 throughout the operation.
